// File: rtl/uart_rx_os.sv
// -----------------------------------------------------------------------------
// uart_rx_os -- 16x oversampling UART receiver (8N1 by default)
//
// Deserialises asynchronous serial frames (start, DATA_BITS data LSB first,
// optional even parity, one stop bit). Each bit is sampled three times around
// its centre and decided by majority vote. Received bytes are presented
// through a one-entry holding register with a valid/ready handshake.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> an even-parity bit follows the data bits; adds port parity_err
//   undefined -> plain 8N1 framing, no parity_err port
//
// Parameters:
//   DIV        clk cycles per 1/16 bit time (2..65535)
//   DATA_BITS  data bits per frame (5..8)
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   rx          serial input, idles high, asynchronous to clk
//   dout        received byte, stable while dout_valid=1
//   dout_valid  holding register full
//   dout_ready  consumer accept (transfer when dout_valid && dout_ready)
//   frame_err   stop bit sampled low for the byte in dout
//   overrun     sticky: a completed frame was dropped (holding register full)
//   err_clr     synchronous clear of overrun
//   rx_busy     frame reception in progress
//   parity_err  (UART_RX_PARITY_EN only) parity mismatch for the byte in dout
// -----------------------------------------------------------------------------
module uart_rx_os #(
    parameter int DIV       = 54,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 frame_err,
    output logic                 overrun,
    input  logic                 err_clr,
    output logic                 rx_busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam logic [15:0] DIV_M1   = 16'(DIV - 1);
    localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t state_reg;
    state_t state_next;

    // ------------------------------------------------------------------
    // Input synchroniser and falling-edge detector
    // ------------------------------------------------------------------
    logic rx_meta_reg;
    logic rx_s_reg;
    logic rx_prev_reg;
    logic start_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_s_reg    <= rx_meta_reg;
            rx_prev_reg <= rx_s_reg;
        end
    end

    // Needs a prior high, so a line held low (break) fires only once.
    assign start_edge = rx_prev_reg & ~rx_s_reg;

    // ------------------------------------------------------------------
    // Oversample tick and sample counter
    // ------------------------------------------------------------------
    logic [15:0] tick_cnt_reg;
    logic [3:0]  sample_cnt_reg;
    logic        os_tick;
    logic        start_go;
    logic        at_cnt9;
    logic        at_cnt15;

    assign os_tick  = (tick_cnt_reg == DIV_M1);
    assign start_go = (state_reg == IDLE) && start_edge;
    assign at_cnt9  = os_tick && (sample_cnt_reg == 4'd9);
    assign at_cnt15 = os_tick && (sample_cnt_reg == 4'd15);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_reg   <= '0;
            sample_cnt_reg <= '0;
        end else begin
            // Restarting on the start edge aligns the sampling phase to it.
            if (start_go || os_tick) begin
                tick_cnt_reg <= '0;
            end else begin
                tick_cnt_reg <= tick_cnt_reg + 16'd1;
            end

            if (start_go) begin
                sample_cnt_reg <= '0;
            end else if (os_tick) begin
                sample_cnt_reg <= sample_cnt_reg + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Three-point majority vote: samples at counts 7 and 8 are held,
    // the count-9 sample is the live synchronised input.
    // ------------------------------------------------------------------
    logic samp7_reg;
    logic samp8_reg;
    logic maj;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp7_reg <= 1'b1;
            samp8_reg <= 1'b1;
        end else if (os_tick) begin
            if (sample_cnt_reg == 4'd7) begin
                samp7_reg <= rx_s_reg;
            end
            if (sample_cnt_reg == 4'd8) begin
                samp8_reg <= rx_s_reg;
            end
        end
    end

    assign maj = (samp7_reg & samp8_reg) | (samp7_reg & rx_s_reg) | (samp8_reg & rx_s_reg);

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    logic [2:0] bit_idx_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start_edge) begin
                    state_next = START;
                end
            end
            START: begin
                if (at_cnt9 && maj) begin
                    state_next = IDLE;              // false start (glitch)
                end else if (at_cnt15) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (at_cnt15 && (bit_idx_reg == LAST_BIT)) begin
`ifdef UART_RX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (at_cnt15) begin
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                // Leave mid stop bit so a back-to-back start edge is not missed.
                if (at_cnt9) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign rx_busy = (state_reg != IDLE);

    // ------------------------------------------------------------------
    // Data path: bit index, shift register, stop/parity capture
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_next;
    logic                 frame_done_reg;
    logic                 stop_bit_reg;

    // LSB-first: the newest bit enters at the top and moves down.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_BITS; gi++) begin : g_shift
            if (gi == DATA_BITS - 1) begin : g_top
                assign shift_next[gi] = maj;
            end else begin : g_low
                assign shift_next[gi] = shift_reg[gi+1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_idx_reg    <= '0;
            shift_reg      <= '0;
            frame_done_reg <= 1'b0;
            stop_bit_reg   <= 1'b1;
        end else begin
            if (start_go || ((state_reg == START) && at_cnt15)) begin
                bit_idx_reg <= '0;
            end else if ((state_reg == DATA) && at_cnt15) begin
                bit_idx_reg <= bit_idx_reg + 3'd1;
            end

            if ((state_reg == DATA) && at_cnt9) begin
                shift_reg <= shift_next;
            end

            // Completion is registered, so the holding register loads one
            // clk after the FSM has already returned to IDLE.
            frame_done_reg <= (state_reg == STOP) && at_cnt9;
            if ((state_reg == STOP) && at_cnt9) begin
                stop_bit_reg <= maj;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_bit_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_bit_reg <= 1'b0;
        end else if ((state_reg == PARITY) && at_cnt9) begin
            parity_bit_reg <= maj;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Holding register and handshake
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] dout_reg;
    logic                 dout_valid_reg;
    logic                 frame_err_reg;
    logic                 overrun_reg;
    logic                 load_ok;
    logic                 drop;

    // A same-edge accept frees the register, so the new byte still loads.
    assign load_ok = frame_done_reg && (!dout_valid_reg || dout_ready);
    assign drop    = frame_done_reg && dout_valid_reg && !dout_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            if (load_ok) begin
                dout_reg       <= shift_reg;
                frame_err_reg  <= ~stop_bit_reg;
                dout_valid_reg <= 1'b1;
            end else if (dout_valid_reg && dout_ready) begin
                dout_valid_reg <= 1'b0;
            end

            // A new drop wins over a coincident clear.
            if (drop) begin
                overrun_reg <= 1'b1;
            end else if (err_clr) begin
                overrun_reg <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_err_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err_reg <= 1'b0;
        end else if (load_ok) begin
            // Even parity: data bits plus parity bit must XOR to zero.
            parity_err_reg <= (^shift_reg) ^ parity_bit_reg;
        end
    end

    assign parity_err = parity_err_reg;
`endif

    assign dout       = dout_reg;
    assign dout_valid = dout_valid_reg;
    assign frame_err  = frame_err_reg;
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_uart_rx_os.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_os -- self-checking bench for uart_rx_os (DIV=4, 64 clk per bit)
//
// Frames are generated bit by bit from the serial protocol; expected bytes and
// error flags come from the transmitted data and stop bit. A negedge monitor
// logs every accepted transfer and every dout_valid rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_os;

    localparam int DIV       = 4;
    localparam int DATA_BITS = 8;
    localparam int BIT_CLK   = 16 * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       dout_ready = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] dout;
    logic       dout_valid;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    uart_rx_os #(
        .DIV       (DIV),
        .DATA_BITS (DATA_BITS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .err_clr    (err_clr),
        .rx_busy    (rx_busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    // ---------------------------------------------------------------
    // Monitor
    // ---------------------------------------------------------------
    logic [7:0] obs_data[$];
    logic       obs_fe[$];
    int         valid_rises = 0;
    bit         rise_busy_ok = 1'b0;
    logic       busy_p1 = 1'b0;
    logic       busy_p2 = 1'b0;
    logic       valid_p1 = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (dout_valid && dout_ready) begin
                obs_data.push_back(dout);
                obs_fe.push_back(frame_err);
                $display("[TB] transfer dout=%02h frame_err=%b", dout, frame_err);
            end
            if (dout_valid && !valid_p1) begin
                valid_rises++;
                rise_busy_ok = (!busy_p1 && busy_p2);
            end
        end
        busy_p2  = busy_p1;
        busy_p1  = rx_busy;
        valid_p1 = dout_valid;
    end

    // ---------------------------------------------------------------
    // Stimulus helpers (inputs change 1 ns after the rising edge)
    // ---------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        rx = 1'b0;
        step(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            step(BIT_CLK);
        end
`ifdef UART_RX_PARITY_EN
        rx = ^d;
        step(BIT_CLK);
`endif
        rx = stop_bit;
        step(BIT_CLK);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_badpar(input logic [7:0] d);
        rx = 1'b0;
        step(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            step(BIT_CLK);
        end
        rx = ~(^d);
        step(BIT_CLK);
        rx = 1'b1;
        step(BIT_CLK);
    endtask
`endif

    // ---------------------------------------------------------------
    // Scenarios
    // ---------------------------------------------------------------
    task automatic test_reset;
        rst = 1'b1;
        step(3);
        tests_run++;
        if (dout !== 8'h00) begin tests_failed++; $display("FAIL reset_dout: got %02h want 00", dout); end
        tests_run++;
        if (dout_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", dout_valid); end
        tests_run++;
        if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        tests_run++;
        if (overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        tests_run++;
        if (rx_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
        rst = 1'b0;
        step(BIT_CLK);
    endtask

    task automatic test_basic;
        dout_ready = 1'b0;
        send_frame(8'hA5, 1'b1);
        for (int i = 0; i < 200 && !dout_valid; i++) step(1);
        tests_run++;
        if (dout_valid !== 1'b1) begin tests_failed++; $display("FAIL basic_valid: got %b want 1 (timeout)", dout_valid); end
        tests_run++;
        if (dout !== 8'hA5) begin tests_failed++; $display("FAIL basic_dout: got %02h want a5", dout); end
        tests_run++;
        if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL basic_frame_err: got %b want 0", frame_err); end
        tests_run++;
        if (overrun !== 1'b0) begin tests_failed++; $display("FAIL basic_overrun: got %b want 0", overrun); end
        tests_run++;
        if (rise_busy_ok !== 1'b1) begin tests_failed++; $display("FAIL basic_busy_before_valid: got %b want 1", rise_busy_ok); end
        dout_ready = 1'b1;
        step(1);
        dout_ready = 1'b0;
        tests_run++;
        if (dout_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_accept: got %b want 0", dout_valid); end
        step(BIT_CLK);
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_data[$];
        logic [7:0] d;
        obs_data.delete();
        obs_fe.delete();
        dout_ready = 1'b1;
        exp_data.push_back(8'hFF);
        exp_data.push_back(8'h00);
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            exp_data.push_back(d);
        end
        foreach (exp_data[i]) send_frame(exp_data[i], 1'b1);
        step(BIT_CLK);
        tests_run++;
        if (obs_data.size() !== exp_data.size()) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d want %0d", obs_data.size(), exp_data.size());
        end else begin
            foreach (exp_data[i]) begin
                tests_run++;
                if (obs_data[i] !== exp_data[i] || obs_fe[i] !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL b2b_byte%0d: got %02h/fe%b want %02h/fe0", i, obs_data[i], obs_fe[i], exp_data[i]);
                end
            end
        end
        dout_ready = 1'b0;
    endtask

    task automatic test_random_gapped;
        logic [7:0] exp_data[$];
        logic       exp_fe[$];
        logic [7:0] d;
        logic       s;
        obs_data.delete();
        obs_fe.delete();
        dout_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            s = ($urandom_range(0, 3) != 0);
            exp_data.push_back(d);
            exp_fe.push_back(~s);
            send_frame(d, s);
            rx = 1'b1;
            step(2 * BIT_CLK);
        end
        tests_run++;
        if (obs_data.size() !== exp_data.size()) begin
            tests_failed++;
            $display("FAIL rand_count: got %0d want %0d", obs_data.size(), exp_data.size());
        end else begin
            foreach (exp_data[i]) begin
                tests_run++;
                if (obs_data[i] !== exp_data[i] || obs_fe[i] !== exp_fe[i]) begin
                    tests_failed++;
                    $display("FAIL rand_byte%0d: got %02h/fe%b want %02h/fe%b", i, obs_data[i], obs_fe[i], exp_data[i], exp_fe[i]);
                end
            end
        end
        dout_ready = 1'b0;
    endtask

    task automatic test_framing;
        int rises0;
        obs_data.delete();
        obs_fe.delete();
        dout_ready = 1'b1;
        rises0 = valid_rises;
        send_frame(8'h3C, 1'b0);
        step(20 * BIT_CLK);              // line held low (break)
        tests_run++;
        if (obs_data.size() !== 1) begin
            tests_failed++;
            $display("FAIL frame_count: got %0d want 1", obs_data.size());
        end else begin
            tests_run++;
            if (obs_data[0] !== 8'h3C || obs_fe[0] !== 1'b1) begin
                tests_failed++;
                $display("FAIL frame_byte: got %02h/fe%b want 3c/fe1", obs_data[0], obs_fe[0]);
            end
        end
        tests_run++;
        if (valid_rises !== rises0 + 1) begin tests_failed++; $display("FAIL frame_break_rises: got %0d want %0d", valid_rises - rises0, 1); end
        tests_run++;
        if (rx_busy !== 1'b0) begin tests_failed++; $display("FAIL frame_break_busy: got %b want 0", rx_busy); end
        rx = 1'b1;
        step(2 * BIT_CLK);
        send_frame(8'h55, 1'b1);
        step(BIT_CLK);
        tests_run++;
        if (obs_data.size() !== 2) begin
            tests_failed++;
            $display("FAIL frame_recover_count: got %0d want 2", obs_data.size());
        end else begin
            tests_run++;
            if (obs_data[1] !== 8'h55 || obs_fe[1] !== 1'b0) begin
                tests_failed++;
                $display("FAIL frame_recover_byte: got %02h/fe%b want 55/fe0", obs_data[1], obs_fe[1]);
            end
        end
        dout_ready = 1'b0;
    endtask

    task automatic test_glitch;
        int  rises0;
        bit  saw_busy;
        rises0 = valid_rises;
        saw_busy = 1'b0;
        rx = 1'b0;
        for (int i = 0; i < 3 * DIV; i++) begin
            step(1);
            if (rx_busy) saw_busy = 1'b1;
        end
        rx = 1'b1;
        for (int i = 0; i < 2 * BIT_CLK; i++) begin
            step(1);
            if (rx_busy) saw_busy = 1'b1;
        end
        tests_run++;
        if (saw_busy !== 1'b1) begin tests_failed++; $display("FAIL glitch_detect: busy seen %b want 1", saw_busy); end
        tests_run++;
        if (rx_busy !== 1'b0) begin tests_failed++; $display("FAIL glitch_busy: got %b want 0", rx_busy); end
        tests_run++;
        if (valid_rises !== rises0 || dout_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL glitch_valid: rises %0d valid %b want 0/0", valid_rises - rises0, dout_valid);
        end
    endtask

    task automatic test_overrun;
        obs_data.delete();
        obs_fe.delete();
        dout_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        step(BIT_CLK);
        send_frame(8'h22, 1'b1);
        step(BIT_CLK);
        tests_run++;
        if (dout !== 8'h11 || dout_valid !== 1'b1) begin tests_failed++; $display("FAIL ovr_hold: got %02h/v%b want 11/v1", dout, dout_valid); end
        tests_run++;
        if (overrun !== 1'b1) begin tests_failed++; $display("FAIL ovr_flag: got %b want 1", overrun); end
        step(5);
        tests_run++;
        if (overrun !== 1'b1) begin tests_failed++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        tests_run++;
        if (overrun !== 1'b0) begin tests_failed++; $display("FAIL ovr_clear: got %b want 0", overrun); end
        dout_ready = 1'b1;
        step(1);
        dout_ready = 1'b0;
        tests_run++;
        if (dout_valid !== 1'b0) begin tests_failed++; $display("FAIL ovr_accept: got %b want 0", dout_valid); end
        tests_run++;
        if (obs_data.size() !== 1 || obs_data[0] !== 8'h11) begin
            tests_failed++;
            $display("FAIL ovr_transfer: got %0d transfers want one of 11", obs_data.size());
        end
        step(4);
    endtask

    task automatic test_reset_mid;
        logic [7:0] d81;
        d81 = 8'h81;
        dout_ready = 1'b0;
        send_frame(8'h33, 1'b1);
        step(BIT_CLK);
        tests_run++;
        if (dout_valid !== 1'b1 || dout !== 8'h33) begin tests_failed++; $display("FAIL rstmid_pre: got %02h/v%b want 33/v1", dout, dout_valid); end
        rx = 1'b0;
        step(BIT_CLK);
        for (int i = 0; i < 4; i++) begin
            rx = d81[i];
            step(BIT_CLK);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (dout !== 8'h00 || dout_valid !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0 || rx_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_async: got d%02h v%b fe%b ov%b busy%b want all 0", dout, dout_valid, frame_err, overrun, rx_busy);
        end
        rx = 1'b1;
        step(4);
        rst = 1'b0;
        step(BIT_CLK);
        send_frame(8'h7E, 1'b1);
        step(BIT_CLK);
        tests_run++;
        if (dout !== 8'h7E || dout_valid !== 1'b1) begin tests_failed++; $display("FAIL rstmid_after: got %02h/v%b want 7e/v1", dout, dout_valid); end
        tests_run++;
        if (frame_err !== 1'b0 || overrun !== 1'b0) begin tests_failed++; $display("FAIL rstmid_flags: got fe%b ov%b want 0/0", frame_err, overrun); end
        dout_ready = 1'b1;
        step(1);
        dout_ready = 1'b0;
        step(4);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        dout_ready = 1'b0;
        send_frame_badpar(8'h07);
        step(BIT_CLK);
        tests_run++;
        if (dout !== 8'h07 || dout_valid !== 1'b1 || parity_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL parity_bad: got %02h/v%b/pe%b want 07/v1/pe1", dout, dout_valid, parity_err);
        end
        dout_ready = 1'b1;
        step(1);
        dout_ready = 1'b0;
        send_frame(8'h07, 1'b1);
        step(BIT_CLK);
        tests_run++;
        if (dout !== 8'h07 || dout_valid !== 1'b1 || parity_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL parity_good: got %02h/v%b/pe%b want 07/v1/pe0", dout, dout_valid, parity_err);
        end
        dout_ready = 1'b1;
        step(1);
        dout_ready = 1'b0;
        step(4);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_random_gapped();
        test_framing();
        test_glitch();
        test_overrun();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Standalone 16x-oversampling UART receiver: the reading end for the uart transmit path (external_tx).
- Deserialises 8N1 frames from an asynchronous serial line, with majority-vote sampling and framing and overrun detection.
- Presents each byte on a valid/ready handshake with a one-entry holding register, so host logic can consume bytes at its own pace.

Parameters:
- DIV, 54, clk cycles per 1/16 bit (100 MHz / (115200*16), truncated); legal range 2..65535.
- DATA_BITS, 8, data bits per frame, sent LSB first; legal range 5..8.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  serial input; idles high; asynchronous to clk.
- dout  out  DATA_BITS  received byte; stable while dout_valid=1.
- dout_valid  out  1  holding register full.
- dout_ready  in  1  consumer accept; transfer occurs on a clk edge where dout_valid&&dout_ready.
- frame_err  out  1  stop bit sampled 0 for the byte in dout; qualified by dout_valid.
- overrun  out  1  sticky: a completed frame was dropped because the holding register was full.
- err_clr  in  1  synchronous clear of overrun.
- rx_busy  out  1  frame reception in progress.

Behaviour:
- Reset (async): dout=0, dout_valid=0, frame_err=0, overrun=0, rx_busy=0, state=IDLE, both synchroniser flops=1, tick counter=0, sample counter=0.
- rx passes through a 2-FF synchroniser (rx_s); rx_s lags rx by 2 clk.
- Tick generator: counts 0..DIV-1 and emits a 1-clk os_tick at DIV-1.
  - Counter is cleared on IDLE->START so sampling phase aligns to the detected edge.
- Sample counter (4-bit) increments per os_tick.
  - Samples taken at counts 7, 8 and 9; bit value = majority of the 3.
  - At count 15 the counter wraps and the bit index advances.
- IDLE:
  - Start detection = falling edge of rx_s (previous rx_s=1, current 0).
  - A line held low, e.g. a break, triggers at most once; a new start needs a prior high.
  - On the edge: -> START, rx_busy=1.
- START: at count 9, majority=1 -> false start, -> IDLE, rx_busy=0. Otherwise, at count 15 -> DATA, bit index=0.
- DATA: at count 9 shift the majority bit into the shift register, LSB first. After bit DATA_BITS-1 completes count 15 -> (PARITY if enabled) else STOP.
- STOP:
  - At count 9, complete the frame, -> IDLE, rx_busy=0.
  - Early return leaves half a bit of margin for back-to-back frames.
  - Frame completion with dout_valid=0 (after any same-edge handshake): dout<=shift register, frame_err<=~stop_majority, dout_valid<=1.
  - Frame completion with dout_valid=1 and no accept that edge: frame dropped, dout and frame_err unchanged, overrun<=1.
  - Completion and accept on the same edge: the new byte is loaded, dout_valid stays 1, no overrun.
- Handshake:
  - dout_valid falls the edge after acceptance unless a frame loads on that same edge.
  - dout_ready while dout_valid=0 is ignored.
- overrun clears only on err_clr. If err_clr and a new overrun coincide, overrun stays set.
- Framing error: the frame is still delivered, with frame_err=1. A line stuck low afterwards produces no further starts until rx_s returns high.
- Latency: dout_valid rises 1 clk after stop-bit count 9, i.e. about 9.5 bit times + 2 clk after the start edge at the pin.
- Reset mid-frame: aborts immediately, partial data is discarded, no flags are set.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - A PARITY state follows DATA; parity is even, taken from the majority at count 9.
  - New output parity_err (1 bit, reset 0), loaded with dout and qualified by dout_valid.
  - A parity-bad frame is still delivered.
  - Frame length becomes 11 bits.
- When undefined: no PARITY state and no parity_err port; frames are 10 bits (8N1).

Test Plan:
- DIV=4 (bit = 64 clk). Send 0xA5 8N1 and hold dout_ready=0 -> dout=8'hA5, dout_valid=1, frame_err=0, overrun=0; rx_busy low 1 clk before dout_valid rises.
- Back-to-back 0xFF then 0x00 with no idle gap, dout_ready=1 -> two valid pulses carrying 8'hFF then 8'h00, no errors.
- Send 0x3C with stop bit driven 0 -> dout=8'h3C, frame_err=1. Hold rx low 20 bit times -> no further dout_valid, rx_busy=0. Release rx, send 0x55 -> 8'h55, frame_err=0.
- Glitch: rx low for 3 oversample ticks only -> false start, back to IDLE, no dout_valid.
- Send 0x11 then 0x22 with dout_ready=0 -> dout stays 8'h11, overrun=1. Pulse err_clr -> overrun=0. Accept -> dout_valid=0.
- Assert rst mid-DATA of 0x81 -> all outputs 0 immediately. Release rst, send 0x7E -> dout=8'h7E with no error. With UART_RX_PARITY_EN defined, send 0x07 with odd-wrong parity bit=0 -> parity_err=1.
